// File: rtl/arb_mux.sv
// N-channel arbitrating multiplexer with one registered output slot.
// Fixed-priority (MODE 0) or round-robin (MODE 1) grant, full throughput, valid/ready on both sides.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW-1:0]   gnt_idx_s;
  logic [SELW:0]     idx_sum_s;
  logic [2*N-1:0]    rot_s;
  logic [N-1:0]      grant_s;
  logic [WIDTH-1:0]  gnt_data_s;
  logic              gnt_found_s;
  logic              can_load_s;
  logic              xfer_s;

  // Rotate requests so the search starts at ptr; in MODE 0 ptr stays 0, giving plain lowest-index priority.
  always_comb begin
    rot_s       = {in_valid, in_valid} >> ptr_q;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    idx_sum_s   = '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_found_s && rot_s[k]) begin
        gnt_found_s = 1'b1;
        idx_sum_s   = {1'b0, ptr_q} + (SELW+1)'(k);
        if (idx_sum_s >= (SELW+1)'(N)) begin
          idx_sum_s = idx_sum_s - (SELW+1)'(N);
        end else begin
          idx_sum_s = idx_sum_s;
        end
        gnt_idx_s = idx_sum_s[SELW-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // One-hot grant, the granted payload, and the gated ready.
  always_comb begin
    grant_s    = '0;
    gnt_data_s = '0;
    for (int i = 0; i < N; i++) begin
      grant_s[i] = gnt_found_s && (gnt_idx_s == SELW'(i));
      if (grant_s[i]) begin
        gnt_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
    can_load_s = (state_q == EMPTY) || out_ready;
    if (rst) begin
      in_ready = '0;
    end else begin
      in_ready = grant_s & {N{can_load_s}};
    end
    xfer_s = |(in_valid & in_ready);
  end

  // Next-state: slot occupancy, captured payload and round-robin pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY: begin
        if (xfer_s) state_d = FULL;
        else        state_d = EMPTY;
      end
      FULL: begin
        if (xfer_s)         state_d = FULL;
        else if (out_ready) state_d = EMPTY;
        else                state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
    if (xfer_s) begin
      data_d = gnt_data_s;
      sel_d  = gnt_idx_s;
    end else begin
      data_d = data_q;
      sel_d  = sel_q;
    end
    if (MODE != 1) begin
      ptr_d = '0;
    end else if (xfer_s) begin
      if (gnt_idx_s == SELW'(N-1)) ptr_d = '0;
      else                         ptr_d = gnt_idx_s + SELW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers with synchronous reset taking precedence over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: fixed-priority and round-robin instances driven in parallel,
// vector table plus scenario sequences, payloads tracked through a scoreboard queue.
module tb_arb_mux;
  localparam int W  = 32;
  localparam int NC = 4;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic         r;
    logic [3:0]   vld;
    logic         ordy;
    logic [127:0] d;
    logic [3:0]   efp;
    logic [3:0]   err;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              out_ready;
  logic [NC*W-1:0]   in_data;
  logic [NC-1:0]     in_valid;
  logic [NC-1:0]     rdy_fp, rdy_rr;
  logic [W-1:0]      od_fp, od_rr;
  logic [1:0]        os_fp, os_rr;
  logic              ov_fp, ov_rr;

  int n_cmp = 0;
  int n_bad = 0;

  bit          full_m [2];
  int          ptr_m  [2];
  logic [31:0] last_d [2];
  logic [1:0]  last_s [2];
  bit          x_m    [2];
  int          g_m    [2];
  sb_t         sb_fp[$];
  sb_t         sb_rr[$];
  vec_t        vt [13];

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .N(NC), .MODE(0)) u_fp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_fp),
    .out_data(od_fp), .out_sel(os_fp), .out_valid(ov_fp), .out_ready(out_ready));

  arb_mux #(.WIDTH(W), .N(NC), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_rr),
    .out_data(od_rr), .out_sel(os_rr), .out_valid(ov_rr), .out_ready(out_ready));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int mgrant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic o,
                              input logic [127:0] d, input logic [3:0] efp, input logic [3:0] err);
    vec_t t;
    t.r = r; t.vld = v; t.ordy = o; t.d = d; t.efp = efp; t.err = err;
    return t;
  endfunction

  task automatic drive(input logic r, input logic [3:0] v, input logic o, input logic [127:0] d);
    rst = r; in_valid = v; out_ready = o; in_data = d;
  endtask

  task automatic chk_mode(input int m, input logic [3:0] rdy, input logic ov, input logic [31:0] od,
                          input logic [1:0] os, input bit use_exp, input logic [3:0] exp_rdy);
    sb_t         e;
    int          g;
    int          sz;
    bit          cl;
    logic [3:0]  er;
    string       tag;
    tag = (m == 0) ? "fp" : "rr";
    check({tag, ".out_valid"}, 32'(ov), 32'(full_m[m]));
    sz = (m == 0) ? sb_fp.size() : sb_rr.size();
    e  = '0;
    if (full_m[m] && sz > 0) begin
      e = (m == 0) ? sb_fp[0] : sb_rr[0];
      check({tag, ".out_data"}, od, e.data);
      check({tag, ".out_sel"}, 32'(os), 32'(e.sel));
    end else if (!full_m[m]) begin
      check({tag, ".held_data"}, od, last_d[m]);
      check({tag, ".held_sel"}, 32'(os), 32'(last_s[m]));
    end
    cl = !full_m[m] || out_ready;
    g  = mgrant(in_valid, ptr_m[m]);
    er = (g >= 0 && cl && !rst) ? 4'(1 << g) : 4'b0000;
    check({tag, ".in_ready"}, 32'(rdy), 32'(er));
    if (use_exp) check({tag, ".in_ready_tbl"}, 32'(rdy), 32'(exp_rdy));
    x_m[m] = (er != 4'b0000);
    g_m[m] = g;
    if (!rst && full_m[m] && out_ready && sz > 0) begin
      if (m == 0) void'(sb_fp.pop_front());
      else        void'(sb_rr.pop_front());
      last_d[m] = e.data;
      last_s[m] = e.sel;
    end
    if (x_m[m]) begin
      e.sel  = 2'(g);
      e.data = in_data[g*32 +: 32];
      if (m == 0) sb_fp.push_back(e);
      else        sb_rr.push_back(e);
    end
  endtask

  task automatic cycle(input bit use_exp, input logic [3:0] efp, input logic [3:0] err);
    @(negedge clk);
    chk_mode(0, rdy_fp, ov_fp, od_fp, os_fp, use_exp, efp);
    chk_mode(1, rdy_rr, ov_rr, od_rr, os_rr, use_exp, err);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        full_m[m] = 1'b0; ptr_m[m] = 0; last_d[m] = 32'h0; last_s[m] = 2'd0;
      end else if (x_m[m]) begin
        full_m[m] = 1'b1;
        if (m == 1) ptr_m[m] = (g_m[m] + 1) % 4;
      end else if (full_m[m] && out_ready) begin
        full_m[m] = 1'b0;
      end
    end
    if (rst) begin
      sb_fp.delete();
      sb_rr.delete();
    end
    #1;
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic o, input logic [127:0] d);
    drive(r, v, o, d);
    cycle(1'b0, 4'b0000, 4'b0000);
  endtask

  initial begin
    logic [127:0] inc;
    logic [127:0] mix;
    inc = {32'h00000003, 32'h00000002, 32'h00000001, 32'h00000000};
    mix = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    for (int m = 0; m < 2; m++) begin
      full_m[m] = 1'b0; ptr_m[m] = 0; last_d[m] = 32'h0; last_s[m] = 2'd0;
      x_m[m] = 1'b0; g_m[m] = -1;
    end

    vt[0]  = mk(1'b1, 4'b1111, 1'b1, inc, 4'b0000, 4'b0000);
    vt[1]  = mk(1'b0, 4'b0110, 1'b1, {32'h0, 32'hABCDEF00, 32'h12345678, 32'h0}, 4'b0010, 4'b0010);
    vt[2]  = mk(1'b0, 4'b0000, 1'b1, inc, 4'b0000, 4'b0000);
    vt[3]  = mk(1'b0, 4'b1111, 1'b1, inc, 4'b0001, 4'b0100);
    vt[4]  = mk(1'b0, 4'b1111, 1'b1, inc, 4'b0001, 4'b1000);
    vt[5]  = mk(1'b0, 4'b1111, 1'b1, inc, 4'b0001, 4'b0001);
    vt[6]  = mk(1'b0, 4'b1111, 1'b0, mix, 4'b0000, 4'b0000);
    vt[7]  = mk(1'b0, 4'b0000, 1'b1, mix, 4'b0000, 4'b0000);
    vt[8]  = mk(1'b0, 4'b0000, 1'b1, mix, 4'b0000, 4'b0000);
    vt[9]  = mk(1'b0, 4'b1010, 1'b1, mix, 4'b0010, 4'b0010);
    vt[10] = mk(1'b0, 4'b1001, 1'b1, mix, 4'b0001, 4'b1000);
    vt[11] = mk(1'b0, 4'b0000, 1'b0, mix, 4'b0000, 4'b0000);
    vt[12] = mk(1'b0, 4'b0000, 1'b1, mix, 4'b0000, 4'b0000);

    drive(1'b1, 4'b0000, 1'b1, 128'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].r, vt[i].vld, vt[i].ordy, vt[i].d);
      cycle(1'b1, vt[i].efp, vt[i].err);
    end

    // Round-robin sweep with wrap, no bubbles.
    step(1'b1, 4'b0000, 1'b1, inc);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b1111, 1'b1, inc);
      check("s2.rr_sel", 32'(os_rr), 32'(k % 4));
      check("s2.rr_valid", 32'(ov_rr), 32'd1);
    end
    step(1'b0, 4'b0000, 1'b1, inc);

    // Backpressure: held payload survives input data changes.
    step(1'b0, 4'b1000, 1'b1, {32'hFFFFFFFF, 32'h0, 32'h0, 32'h0});
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0001, 1'b0, {32'h0, 32'h0, 32'h0, 32'h11111111});
      check("s3.fp_hold_data", od_fp, 32'hFFFFFFFF);
      check("s3.rr_hold_sel", 32'(os_rr), 32'd3);
    end
    step(1'b0, 4'b0001, 1'b1, {32'h0, 32'h0, 32'h0, 32'h11111111});
    check("s3.fp_load_data", od_fp, 32'h11111111);
    check("s3.rr_load_sel", 32'(os_rr), 32'd0);
    step(1'b0, 4'b0000, 1'b1, inc);

    // Simultaneous output accept and input load.
    step(1'b0, 4'b0001, 1'b1, {32'h0, 32'h0, 32'h0, 32'hAAAAAAAA});
    step(1'b0, 4'b0100, 1'b1, {32'h0, 32'h55555555, 32'h0, 32'h0});
    check("s4.fp_valid", 32'(ov_fp), 32'd1);
    check("s4.rr_data", od_rr, 32'h55555555);
    check("s4.fp_sel", 32'(os_fp), 32'd2);
    step(1'b0, 4'b0000, 1'b1, inc);

    // Reset while full and stalled.
    step(1'b0, 4'b0010, 1'b1, {32'h0, 32'h0, 32'h0F0F0F0F, 32'h0});
    step(1'b0, 4'b0000, 1'b0, inc);
    step(1'b1, 4'b1111, 1'b0, inc);
    check("s5.rr_valid", 32'(ov_rr), 32'd0);
    check("s5.rr_data", od_rr, 32'h0);
    check("s5.fp_sel", 32'(os_fp), 32'd0);
    step(1'b0, 4'b1111, 1'b1, inc);
    check("s5.rr_first_sel", 32'(os_rr), 32'd0);

    // Drain then idle: pointer must not drift.
    step(1'b0, 4'b0000, 1'b1, inc);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b0000, 1'b1, inc);
      check("s6.rr_ready", 32'(rdy_rr), 32'd0);
      check("s6.rr_valid", 32'(ov_rr), 32'd0);
    end
    step(1'b0, 4'b1111, 1'b1, inc);
    check("s6.rr_sel", 32'(os_rr), 32'd1);
    check("s6.fp_sel", 32'(os_fp), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
